// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Signal bundle between the scan/timing generator, the frame compositor and
//   the panel pins.
//
//   master : the timing generator (drives coordinates and panel signals)
//   slave  : the compositor / panel side (drives pixel_in and test_mode)
//
//   test_mode   : selects internal colour bars (only honoured when the DUT is
//                 built with VGA_TIMING_TEST_PATTERN_EN)
//   pixel_in    : RGB from the compositor, {R[23:16],G[15:8],B[7:0]}
//   vga_h/vga_v : raw scan counters presented to the compositor
//   hsync/vsync : panel sync outputs
//   de          : panel data enable
//   rgb_out     : panel pixel, zero whenever de is low
//   frame_start : one-clock pulse aligned with output pixel (0,0)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic        test_mode;
    logic [23:0] pixel_in;
    logic [10:0] vga_h;
    logic [10:0] vga_v;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] rgb_out;
    logic        frame_start;

    modport master (
        input  test_mode, pixel_in,
        output vga_h, vga_v, hsync, vsync, de, rgb_out, frame_start
    );

    modport slave (
        output test_mode, pixel_in,
        input  vga_h, vga_v, hsync, vsync, de, rgb_out, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Scan/timing source for the 800x480 video path. Free-running h/v counters
//   are presented to the frame compositor on vga_h/vga_v; the compositor's
//   pixel comes back on pixel_in PIXEL_LATENCY clocks later. The timing flags
//   are delayed to match, so every panel output at clock t describes the
//   coordinate presented at clock t-(PIXEL_LATENCY+1).
//
//   Ports:
//     clk     : pixel clock
//     reset_n : asynchronous active-low reset; release is expected to be
//               synchronous to clk (no internal synchroniser, so the first
//               clock after release presents (0,0))
//     bus     : vga_timing_gen_if.master (see interface file)
//
//   Optional build macro VGA_TIMING_TEST_PATTERN_EN: when defined, test_mode=1
//   replaces pixel_in with eight 100-pixel colour bars derived from the
//   aligned h position. When undefined, test_mode is ignored.
//
//   Constraint: H_TOTAL and V_TOTAL must not exceed 2047 (11-bit counters).
//   PIXEL_LATENCY legal range is 1..8.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE      = 800,
    parameter int H_FP          = 40,
    parameter int H_SYNC        = 48,
    parameter int H_BP          = 40,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 13,
    parameter int V_SYNC        = 3,
    parameter int V_BP          = 29,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;

    logic act_p0, hs_p0, vs_p0, fs_p0;

    logic [PIXEL_LATENCY-1:0] act_p1;
    logic [PIXEL_LATENCY-1:0] hs_p1;
    logic [PIXEL_LATENCY-1:0] vs_p1;
    logic [PIXEL_LATENCY-1:0] fs_p1;

    logic        de_p2;
    logic        hsync_p2;
    logic        vsync_p2;
    logic        fs_p2;
    logic [23:0] rgb_p2;

    logic [23:0] pix_sel;

    // ---- p0: free-running scan counters and raw timing flags --------------
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? 11'd0 : h_cnt + 11'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
            end
        end
    end

    always_comb begin
        act_p0 = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_p0  = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_p0  = (v_cnt >= VS_START) && (v_cnt < VS_END);
        fs_p0  = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    // ---- p1: delay line matching the compositor latency -------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_p1 <= '0;
            hs_p1  <= '0;
            vs_p1  <= '0;
            fs_p1  <= '0;
        end else begin
            act_p1[0] <= act_p0;
            hs_p1[0]  <= hs_p0;
            vs_p1[0]  <= vs_p0;
            fs_p1[0]  <= fs_p0;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                act_p1[i] <= act_p1[i-1];
                hs_p1[i]  <= hs_p1[i-1];
                vs_p1[i]  <= vs_p1[i-1];
                fs_p1[i]  <= fs_p1[i-1];
            end
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    // The h position and test_mode travel with the flags so a mode switch
    // lands on the output with the same latency as the coordinate it
    // was sampled with.
    logic [10:0]              hpos_p1 [PIXEL_LATENCY];
    logic [PIXEL_LATENCY-1:0] tm_p1;

    function automatic logic [23:0] bar_colour(input logic [10:0] h);
        logic [23:0] c;
        if      (h < 11'd100) c = 24'hFFFFFF;
        else if (h < 11'd200) c = 24'hFFFF00;
        else if (h < 11'd300) c = 24'h00FFFF;
        else if (h < 11'd400) c = 24'h00FF00;
        else if (h < 11'd500) c = 24'hFF00FF;
        else if (h < 11'd600) c = 24'hFF0000;
        else if (h < 11'd700) c = 24'h0000FF;
        else                  c = 24'h000000;
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_p1 <= '0;
            for (int i = 0; i < PIXEL_LATENCY; i++) begin
                hpos_p1[i] <= '0;
            end
        end else begin
            tm_p1[0]   <= bus.test_mode;
            hpos_p1[0] <= h_cnt;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                tm_p1[i]   <= tm_p1[i-1];
                hpos_p1[i] <= hpos_p1[i-1];
            end
        end
    end

    assign pix_sel = tm_p1[PIXEL_LATENCY-1] ? bar_colour(hpos_p1[PIXEL_LATENCY-1])
                                            : bus.pixel_in;
`else
    logic unused_test_mode;
    assign unused_test_mode = bus.test_mode;
    assign pix_sel          = bus.pixel_in;
`endif

    // ---- p2: output register, pixel gated by the aligned data enable ------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_p2    <= 1'b0;
            hsync_p2 <= ~HSYNC_POL;
            vsync_p2 <= ~VSYNC_POL;
            fs_p2    <= 1'b0;
            rgb_p2   <= '0;
        end else begin
            de_p2    <= act_p1[PIXEL_LATENCY-1];
            hsync_p2 <= hs_p1[PIXEL_LATENCY-1] ? HSYNC_POL : ~HSYNC_POL;
            vsync_p2 <= vs_p1[PIXEL_LATENCY-1] ? VSYNC_POL : ~VSYNC_POL;
            fs_p2    <= fs_p1[PIXEL_LATENCY-1];
            rgb_p2   <= act_p1[PIXEL_LATENCY-1] ? pix_sel : 24'h000000;
        end
    end

    assign bus.vga_h       = h_cnt;
    assign bus.vga_v       = v_cnt;
    assign bus.de          = de_p2;
    assign bus.hsync       = hsync_p2;
    assign bus.vsync       = vsync_p2;
    assign bus.frame_start = fs_p2;
    assign bus.rgb_out     = rgb_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen with a shortened vertical timing so a
//   full frame fits in a short run. Horizontal timing is the default 800-pixel
//   line. A small compositor model feeds pixel_in from the coordinates it saw
//   two clocks earlier; expected panel outputs are queued per presented
//   coordinate and popped when the matching output clock arrives.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 800, HF = 40, HS = 48, HB = 40;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 20, VF = 3, VS = 3, VB = 4;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        de;
        logic        hs_lvl;
        logic        vs_lvl;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    typedef struct packed {
        logic        act;
        logic [10:0] h;
        logic [10:0] v;
    } crd_t;

    localparam exp_t RST_E = '{de: 1'b0, hs_lvl: 1'b1, vs_lvl: 1'b1, fs: 1'b0, rgb: 24'h0};

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    vga_timing_gen_if vif();

    vga_timing_gen #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vif)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    crd_t hist[$];
    int   mh, mv, cyc;
    int   fs_n, fs_first, de_frame, hs_frame, vs_frame, hs_first, vs_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] bar(input int h);
        case (h / 100)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic exp_t model(input int h, input int v, input bit tm);
        exp_t e;
        e.de     = (h < HA) && (v < VA);
        e.hs_lvl = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs_lvl = !((v >= VA + VF) && (v < VA + VF + VS));
        e.fs     = (h == 0) && (v == 0);
        if (!e.de)             e.rgb = 24'h000000;
        else if (tm && PAT_EN) e.rgb = bar(h);
        else                   e.rgb = {h[7:0], v[7:0], 8'hA5};
        return e;
    endfunction

    task automatic check_reset_state();
        check("rst_de",    vif.de,          1'b0);
        check("rst_rgb",   vif.rgb_out,     24'h0);
        check("rst_fs",    vif.frame_start, 1'b0);
        check("rst_hsync", vif.hsync,       1'b1);
        check("rst_vsync", vif.vsync,       1'b1);
        check("rst_vga_h", vif.vga_h,       11'd0);
        check("rst_vga_v", vif.vga_v,       11'd0);
    endtask

    task automatic hold_reset(input int n);
        reset_n = 1'b0;
        #1;
        check_reset_state();
        repeat (n) begin
            @(posedge clk);
            #1;
            check_reset_state();
        end
    endtask

    task automatic release_reset();
        reset_n  = 1'b1;
        mh       = 0;
        mv       = 0;
        cyc      = 0;
        fs_n     = 0;
        fs_first = 0;
        de_frame = 0;
        hs_frame = 0;
        vs_frame = 0;
        hs_first = -1;
        vs_first = -1;
        sb.delete();
        hist.delete();
        repeat (3) sb.push_back(RST_E);
        repeat (2) hist.push_back('0);
    endtask

    // One pixel clock: compare the output due now, feed the compositor model,
    // queue the expectation for the coordinate presented now, then advance.
    task automatic step(input bit tm);
        exp_t e;
        crd_t c;
        e = sb.pop_front();
        check("de",          vif.de,          e.de);
        check("hsync",       vif.hsync,       e.hs_lvl);
        check("vsync",       vif.vsync,       e.vs_lvl);
        check("frame_start", vif.frame_start, e.fs);
        check("rgb_out",     vif.rgb_out,     e.rgb);
        check("vga_h",       vif.vga_h,       mh);
        check("vga_v",       vif.vga_v,       mv);

        if (vif.frame_start) begin
            fs_n++;
            if (fs_n == 1) begin
                fs_first = cyc;
                check("fs_first_clock", cyc, 3);
            end else if (fs_n == 2) begin
                check("frame_period",  cyc - fs_first,      FRAME);
                check("de_per_frame",  de_frame,            HA * VA);
                check("hs_low_frame",  hs_frame,            HS * VT);
                check("vs_low_frame",  vs_frame,            VS * HT);
                check("hsync_start",   hs_first - fs_first, HA + HF);
                check("vsync_start",   vs_first - fs_first, (VA + VF) * HT);
            end
        end
        if (fs_n == 1) begin
            if (vif.de) de_frame++;
            if (!vif.hsync) begin
                hs_frame++;
                if (hs_first < 0) hs_first = cyc;
            end
            if (!vif.vsync) begin
                vs_frame++;
                if (vs_first < 0) vs_first = cyc;
            end
        end

        c = hist.pop_front();
        vif.pixel_in  = c.act ? {c.h[7:0], c.v[7:0], 8'hA5} : 24'hFFFFFF;
        vif.test_mode = tm;
        c.act = (mh < HA) && (mv < VA);
        c.h   = 11'(mh);
        c.v   = 11'(mv);
        hist.push_back(c);
        sb.push_back(model(mh, mv, tm));

        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit tm;
        vif.test_mode = 1'b0;
        vif.pixel_in  = 24'h0;
        reset_n       = 1'b0;
        cyc           = 0;
        @(posedge clk);
        #1;
        hold_reset(5);

        // Full frame plus ten lines, stopping with (400,10) on the counters.
        release_reset();
        repeat (FRAME + 10 * HT + 400) step(1'b0);
        check("fs_count_seg1", fs_n, 2);
        check("pre_reset_h", vif.vga_h, 11'd400);
        check("pre_reset_v", vif.vga_v, 11'd10);

        // Mid-frame reset: outputs must drop at once, then scan restarts.
        hold_reset(5);
        release_reset();

        // Test mode on for the start of line 0, off from h=350, on for line 1,
        // then toggling every 16 clocks.
        for (int i = 0; i < 2200; i++) begin
            if (mv == 0)      tm = (mh < 350);
            else if (mv == 1) tm = 1'b1;
            else              tm = mh[4];
            step(tm);
        end
        check("fs_count_seg2", fs_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
